serdesphy_ana_rx_ctrl: RTL and testbench

// - Power-up/loss-of-signal sequencer for the RX differential receiver (limiting amp).
// - Drives the receiver's enable/iso_en/lpbk_en, waits analog settle time, then

---
 rtl/serdesphy_ana_rx_ctrl.sv | 109 ++++++++++
 tb/tb_serdesphy_ana_rx_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serdesphy_ana_rx_ctrl.sv
// serdesphy_ana_rx_ctrl: RX limiting-amp power-up / loss-of-signal sequencer (optional status counter via SERDESPHY_RX_CTRL_STATUS_EN)
module serdesphy_ana_rx_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int DET_ON_CNT    = 16,
  parameter int DET_OFF_CNT   = 32,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en_req,
  input  logic       lpbk_req,
  input  logic       sig_det_raw,
  output logic       rx_enable,
  output logic       rx_iso_en,
  output logic       rx_lpbk_en,
  output logic       rx_ready,
  output logic       los,
  output logic       los_event,
  output logic [1:0] state
`ifdef SERDESPHY_RX_CTRL_STATUS_EN
  ,
  input  logic       los_cnt_clr,
  output logic [7:0] los_cnt
`endif
);
  typedef enum logic [1:0] {OFF = 2'd0, PWRUP = 2'd1, ACQ = 2'd2, LOCKED = 2'd3} state_t;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic lpbk_n, los_n, evt_n;
  assign state = st;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  // Next-state logic: disable beats loopback change beats normal sequencing
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    lpbk_n = rx_lpbk_en;
    los_n  = los;
    evt_n  = 1'b0;
    if (!rx_en_req) begin
      st_n  = OFF;
      cnt_n = '0;
      los_n = 1'b0;
    end else if (st != OFF && lpbk_req != rx_lpbk_en) begin
      st_n   = PWRUP;
      lpbk_n = lpbk_req;
      cnt_n  = '0;
    end else begin
      unique case (st)
        OFF: begin
          st_n   = PWRUP;
          lpbk_n = lpbk_req;
          cnt_n  = '0;
        end
        PWRUP: begin
          st_n  = cnt == CNT_W'(SETTLE_CYCLES - 1) ? ACQ : PWRUP;
          cnt_n = cnt == CNT_W'(SETTLE_CYCLES - 1) ? '0 : cnt_inc;
        end
        ACQ: begin
          if (!sig_det_raw) cnt_n = '0;
          else if (cnt == CNT_W'(DET_ON_CNT - 1)) begin
            st_n  = LOCKED;
            cnt_n = '0;
            los_n = 1'b0;
          end else cnt_n = cnt_inc;
        end
        LOCKED: begin
          if (sig_det_raw) cnt_n = '0;
          else if (cnt == CNT_W'(DET_OFF_CNT - 1)) begin
            st_n  = ACQ;
            cnt_n = '0;
            los_n = 1'b1;
            evt_n = 1'b1;
          end else cnt_n = cnt_inc;
        end
        default: st_n = OFF;
      endcase
    end
  end
  // State, counter and registered analog/status outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= OFF;
      cnt        <= '0;
      rx_enable  <= 1'b0;
      rx_iso_en  <= 1'b1;
      rx_lpbk_en <= 1'b0;
      rx_ready   <= 1'b0;
      los        <= 1'b0;
      los_event  <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      rx_enable  <= st_n != OFF;
      rx_iso_en  <= st_n == OFF || st_n == PWRUP;
      rx_lpbk_en <= lpbk_n;
      rx_ready   <= st_n == LOCKED;
      los        <= los_n;
      los_event  <= evt_n;
    end
  end
`ifdef SERDESPHY_RX_CTRL_STATUS_EN
  // Saturating LOS event counter; clear takes priority over a same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) los_cnt <= '0;
    else if (los_cnt_clr) los_cnt <= '0;
    else if (evt_n && los_cnt != 8'hff) los_cnt <= los_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_serdesphy_ana_rx_ctrl.sv
// tb_serdesphy_ana_rx_ctrl: directed self-checking bench for the RX power-up / LOS sequencer
module tb_serdesphy_ana_rx_ctrl;
  logic clk = 1'b0;
  logic rst, rx_en_req, lpbk_req, sig_det_raw;
  logic rx_enable, rx_iso_en, rx_lpbk_en, rx_ready, los, los_event;
  logic [1:0] state;
  int checks = 0;
  int failures = 0;
`ifdef SERDESPHY_RX_CTRL_STATUS_EN
  logic los_cnt_clr;
  logic [7:0] los_cnt;
`endif

  serdesphy_ana_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx_en_req(rx_en_req), .lpbk_req(lpbk_req), .sig_det_raw(sig_det_raw),
    .rx_enable(rx_enable), .rx_iso_en(rx_iso_en), .rx_lpbk_en(rx_lpbk_en), .rx_ready(rx_ready),
    .los(los), .los_event(los_event), .state(state)
`ifdef SERDESPHY_RX_CTRL_STATUS_EN
    , .los_cnt_clr(los_cnt_clr), .los_cnt(los_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bring_up();
    rx_en_req = 1'b0;
    step(1);
    rx_en_req = 1'b1;
    sig_det_raw = 1'b1;
    step(81);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_en_req = 1'b0; lpbk_req = 1'b0; sig_det_raw = 1'b0;
`ifdef SERDESPHY_RX_CTRL_STATUS_EN
    los_cnt_clr = 1'b0;
`endif
    step(3);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (rx_enable !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", rx_enable); end
    checks++; if (rx_iso_en !== 1'b1) begin failures++; $display("FAIL reset_iso got=%b exp=1", rx_iso_en); end
    checks++; if (rx_lpbk_en !== 1'b0) begin failures++; $display("FAIL reset_lpbk got=%b exp=0", rx_lpbk_en); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rx_ready); end
    checks++; if (los !== 1'b0 || los_event !== 1'b0) begin failures++; $display("FAIL reset_los got=%b%b exp=00", los, los_event); end
    rst = 1'b0;
    step(2);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_off got=%0d exp=0", state); end
  endtask

  task automatic test_powerup();
    rx_en_req = 1'b1; sig_det_raw = 1'b1;
    step(1);
    checks++; if (state !== 2'd1 || rx_enable !== 1'b1 || rx_iso_en !== 1'b1) begin failures++; $display("FAIL pwrup_entry got=st%0d en%b iso%b exp=st1 en1 iso1", state, rx_enable, rx_iso_en); end
    step(63);
    checks++; if (state !== 2'd1 || rx_iso_en !== 1'b1) begin failures++; $display("FAIL pwrup_63 got=st%0d iso%b exp=st1 iso1", state, rx_iso_en); end
    step(1);
    checks++; if (state !== 2'd2 || rx_iso_en !== 1'b0 || rx_enable !== 1'b1) begin failures++; $display("FAIL pwrup_64 got=st%0d iso%b en%b exp=st2 iso0 en1", state, rx_iso_en, rx_enable); end
    step(15);
    checks++; if (state !== 2'd2 || rx_ready !== 1'b0) begin failures++; $display("FAIL acq_15 got=st%0d rdy%b exp=st2 rdy0", state, rx_ready); end
    step(1);
    checks++; if (state !== 2'd3 || rx_ready !== 1'b1) begin failures++; $display("FAIL lock_16 got=st%0d rdy%b exp=st3 rdy1", state, rx_ready); end
  endtask

  task automatic test_acq_debounce();
    rx_en_req = 1'b0;
    step(1);
    checks++; if (state !== 2'd0 || rx_ready !== 1'b0) begin failures++; $display("FAIL disable got=st%0d rdy%b exp=st0 rdy0", state, rx_ready); end
    rx_en_req = 1'b1; sig_det_raw = 1'b0;
    step(65);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL acq_entry got=%0d exp=2", state); end
    sig_det_raw = 1'b1;
    step(15);
    sig_det_raw = 1'b0;
    step(1);
    checks++; if (state !== 2'd2 || rx_ready !== 1'b0) begin failures++; $display("FAIL glitch_nolock got=st%0d rdy%b exp=st2 rdy0", state, rx_ready); end
    sig_det_raw = 1'b1;
    step(15);
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL relock_15 got=%b exp=0", rx_ready); end
    step(1);
    checks++; if (state !== 2'd3 || rx_ready !== 1'b1) begin failures++; $display("FAIL relock_16 got=st%0d rdy%b exp=st3 rdy1", state, rx_ready); end
  endtask

  task automatic test_los();
    sig_det_raw = 1'b0;
    step(31);
    sig_det_raw = 1'b1;
    step(1);
    checks++; if (state !== 2'd3 || los !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL los_31 got=st%0d los%b exp=st3 los0", state, los); end
    sig_det_raw = 1'b0;
    step(31);
    checks++; if (state !== 2'd3 || los_event !== 1'b0) begin failures++; $display("FAIL los_pre got=st%0d ev%b exp=st3 ev0", state, los_event); end
    step(1);
    checks++; if (state !== 2'd2 || los_event !== 1'b1 || los !== 1'b1 || rx_ready !== 1'b0) begin failures++; $display("FAIL los_32 got=st%0d ev%b los%b rdy%b exp=st2 ev1 los1 rdy0", state, los_event, los, rx_ready); end
    sig_det_raw = 1'b1;
    step(1);
    checks++; if (los_event !== 1'b0 || los !== 1'b1) begin failures++; $display("FAIL los_pulse got=ev%b los%b exp=ev0 los1", los_event, los); end
    step(14);
    checks++; if (rx_ready !== 1'b0 || los !== 1'b1) begin failures++; $display("FAIL los_relock15 got=rdy%b los%b exp=rdy0 los1", rx_ready, los); end
    step(1);
    checks++; if (state !== 2'd3 || rx_ready !== 1'b1 || los !== 1'b0) begin failures++; $display("FAIL los_relock16 got=st%0d rdy%b los%b exp=st3 rdy1 los0", state, rx_ready, los); end
  endtask

  task automatic test_lpbk();
    lpbk_req = 1'b1;
    step(1);
    checks++; if (state !== 2'd1 || rx_iso_en !== 1'b1 || rx_lpbk_en !== 1'b1 || rx_ready !== 1'b0 || rx_enable !== 1'b1) begin failures++; $display("FAIL lpbk_entry got=st%0d iso%b lp%b rdy%b exp=st1 iso1 lp1 rdy0", state, rx_iso_en, rx_lpbk_en, rx_ready); end
    step(63);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL lpbk_63 got=%0d exp=1", state); end
    step(1);
    checks++; if (state !== 2'd2 || rx_iso_en !== 1'b0 || rx_lpbk_en !== 1'b1) begin failures++; $display("FAIL lpbk_64 got=st%0d iso%b lp%b exp=st2 iso0 lp1", state, rx_iso_en, rx_lpbk_en); end
    lpbk_req = 1'b0;
    step(1);
    checks++; if (state !== 2'd1 || rx_lpbk_en !== 1'b0) begin failures++; $display("FAIL lpbk_off got=st%0d lp%b exp=st1 lp0", state, rx_lpbk_en); end
    step(10);
    rx_en_req = 1'b0;
    step(1);
    checks++; if (state !== 2'd0 || rx_enable !== 1'b0 || rx_iso_en !== 1'b1) begin failures++; $display("FAIL pwrup_abort got=st%0d en%b iso%b exp=st0 en0 iso1", state, rx_enable, rx_iso_en); end
  endtask

  task automatic test_async_reset();
    rx_en_req = 1'b1; sig_det_raw = 1'b1;
    step(70);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL pre_rst got=%0d exp=2", state); end
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || rx_enable !== 1'b0 || rx_iso_en !== 1'b1) begin failures++; $display("FAIL async_rst got=st%0d en%b iso%b exp=st0 en0 iso1", state, rx_enable, rx_iso_en); end
    step(1);
    rst = 1'b0;
  endtask

`ifdef SERDESPHY_RX_CTRL_STATUS_EN
  task automatic los_cycle();
    sig_det_raw = 1'b0;
    step(32);
    sig_det_raw = 1'b1;
    step(16);
  endtask

  task automatic test_status();
    checks++; if (los_cnt !== 8'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", los_cnt); end
    bring_up();
    los_cycle(); los_cycle(); los_cycle();
    checks++; if (los_cnt !== 8'd3) begin failures++; $display("FAIL cnt_3 got=%0d exp=3", los_cnt); end
    sig_det_raw = 1'b0;
    step(31);
    los_cnt_clr = 1'b1;
    step(1);
    los_cnt_clr = 1'b0;
    checks++; if (los_event !== 1'b1 || los_cnt !== 8'd0) begin failures++; $display("FAIL clr_coinc got=ev%b cnt%0d exp=ev1 cnt0", los_event, los_cnt); end
    sig_det_raw = 1'b1;
    step(16);
    los_cycle();
    checks++; if (los_cnt !== 8'd1) begin failures++; $display("FAIL cnt_1 got=%0d exp=1", los_cnt); end
    los_cnt_clr = 1'b1;
    step(1);
    los_cnt_clr = 1'b0;
    checks++; if (los_cnt !== 8'd0) begin failures++; $display("FAIL cnt_clr got=%0d exp=0", los_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_acq_debounce();
    test_los();
    test_lpbk();
    test_async_reset();
`ifdef SERDESPHY_RX_CTRL_STATUS_EN
    test_status();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
